wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writeback stage feeding the register file's two write ports. Registers the CPU
//  pipeline result onto port A. Buffers NPU results in a small FIFO and drains them
//  onto port B. Exports a pending-rd mask so hazard logic can stall readers of
//  registers whose NPU results are still queued.
// PARAMETERS
//  XLEN        64  data width of every writeback
//  REG_AW      5   register address width (2**REG_AW architectural registers)
//  NPU_DEPTH   4   NPU result FIFO entries; power of two, >=2
// PORTS
//  clk              in   1          core clock, rising edge
//  rst_n            in   1          asynchronous active-low reset
//  cpu_wb_valid     in   1          CPU result valid this cycle; no backpressure
//  cpu_wb_rd        in   REG_AW     CPU destination register
//  cpu_wb_data      in   XLEN       CPU result
//  npu_wb_valid     in   1          NPU result offered
//  npu_wb_ready     out  1          FIFO can accept; transfer = valid & ready
//  npu_wb_rd        in   REG_AW     NPU destination register
//  npu_wb_data      in   XLEN       NPU result
//  write_enable_a   out  1          register-file port A enable (registered)
//  write_addr_a     out  REG_AW     port A address (registered)
//  write_data_a     out  XLEN       port A data (registered)
//  write_enable_b   out  1          register-file port B enable (registered)
//  write_addr_b     out  REG_AW     port B address (registered)
//  write_data_b     out  XLEN       port B data (registered)
//  npu_pending      out  2**REG_AW  bit r = some queued NPU entry targets r (combinational)
//  npu_fifo_count   out  $clog2(NPU_DEPTH)+1  occupancy
//  wb_conflict      out  1          sticky: same-rd collision seen on A and B
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, wb_conflict 0. npu_wb_ready=1 right after reset.
//    Async assert; deassert is sampled at clk.
//  - Port A, latency 1: a cycle-N valid with rd!=0 gives write_enable_a=1 at N+1,
//    with that rd and data. If rd==0, the request is dropped and enable stays 0.
//  - NPU accept: npu_wb_ready = (count < NPU_DEPTH). No same-cycle pass-through
//    when full. A transfer with rd==0 is consumed and not enqueued.
//  - Port B drain: head eligible when FIFO non-empty at cycle N.
//    - No collision: pop, and drive write_enable_b with the head at N+1.
//    - Collision (cpu_wb_valid & cpu_wb_rd==head.rd & rd!=0): port A wins. Head held
//      one cycle, write_enable_b=0 at N+1, wb_conflict set until reset. Head retries
//      next cycle. Hazard logic must not let this happen; it is an error indicator.
//  - Push and pop in the same cycle: count unchanged; legal at full (ready still
//    follows the count<DEPTH rule) and at empty (push only, no pop).
//  - Pointers are REG_AW-independent, $clog2(NPU_DEPTH) bits, and wrap modulo depth.
//    Count saturates by construction; overflow/underflow impossible with the handshake.
//  - npu_pending: OR of one-hot(rd) over valid entries, combinational from FIFO
//    state. Bit 0 is always 0. A bit clears the cycle after its last entry pops,
//    i.e. the same edge write_enable_b asserts.
//  - FIFO ordering strict; NPU results retire in arrival order.
//  - Reset mid-operation discards queued entries; no write is issued for them.
// STRUCTURE
//  - osyrys_pkg: XLEN, REG_AW constants; typedef struct packed {logic [REG_AW-1:0] rd;
//    logic [XLEN-1:0] data;} wb_req_t.
//  - Sub-module wb_fifo (sync FIFO of wb_req_t, params DEPTH; ports push/pop/full/empty/
//    count, exposes entry valid+rd vector for the pending mask).
//  - Top: port-A register, drain/collision logic, port-B register, sticky flag.
// TESTING
//  1. cpu valid rd=5 data=0xDEAD at N -> en_a=1, addr_a=5, data_a=0xDEAD at N+1;
//     rd=0 -> en_a=0.
//  2. Push NPU rd=7,8,9,10 back-to-back with no CPU traffic -> ready deasserts after
//     the 4th? No: it drains concurrently; en_b writes 7,8,9,10 in order on consecutive
//     cycles, pending bits 7..10 set then clear one per cycle.
//  3. Hold drain by collisions so the FIFO fills: count=4, ready=0; next cycle free ->
//     pop, count=3, ready=1.
//  4. FIFO head rd=12 and cpu rd=12 same cycle -> en_a writes 12, en_b=0, wb_conflict=1
//     (sticky); next cycle en_b writes 12.
//  5. Push NPU rd=0 data=0x1 -> accepted, count stays 0, no en_b.
//  6. Assert rst_n=0 mid-drain with 3 queued -> all outputs 0 asynchronously,
//     pending=0; after release no stale writes.

Source files
------------

// File: rtl/osyrys_pkg.sv
// rtl/osyrys_pkg.sv - shared writeback widths and request type
package osyrys_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - sync FIFO of writeback requests with per-register pending mask
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 64,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [AW-1:0]     push_rd_i,
    input  logic [DW-1:0]     push_data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [CW-1:0]     count_o,
    output logic [AW-1:0]     head_rd_o,
    output logic [DW-1:0]     head_data_o,
    output logic [2**AW-1:0]  pending_o
);

    logic [AW-1:0] rd_mem   [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] offset;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: validity is tracked purely by pointers and count.
    always_ff @(posedge clk) begin
        if (push_i) begin
            rd_mem[wr_ptr_q]   <= push_rd_i;
            data_mem[wr_ptr_q] <= push_data_i;
        end
    end

    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_rd_o   = rd_mem[rd_ptr_q];
    assign head_data_o = data_mem[rd_ptr_q];

    // Slot i is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        pending_o = '0;
        offset    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - rd_ptr_q;
            if ({1'b0, offset} < count_q) pending_o[rd_mem[i]] = 1'b1;
        end
        pending_o[0] = 1'b0;
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback stage: CPU onto port A, queued NPU results onto port B
module wb_arbiter #(
    parameter int XLEN      = osyrys_pkg::XLEN,
    parameter int REG_AW    = osyrys_pkg::REG_AW,
    parameter int NPU_DEPTH = 4,
    localparam int CW       = $clog2(NPU_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_wb_valid,
    input  logic [REG_AW-1:0]    cpu_wb_rd,
    input  logic [XLEN-1:0]      cpu_wb_data,
    input  logic                 npu_wb_valid,
    output logic                 npu_wb_ready,
    input  logic [REG_AW-1:0]    npu_wb_rd,
    input  logic [XLEN-1:0]      npu_wb_data,
    output logic                 write_enable_a,
    output logic [REG_AW-1:0]    write_addr_a,
    output logic [XLEN-1:0]      write_data_a,
    output logic                 write_enable_b,
    output logic [REG_AW-1:0]    write_addr_b,
    output logic [XLEN-1:0]      write_data_b,
    output logic [2**REG_AW-1:0] npu_pending,
    output logic [CW-1:0]        npu_fifo_count,
    output logic                 wb_conflict
);

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty, collide;
    logic [REG_AW-1:0] head_rd;
    logic [XLEN-1:0]   head_data;

    logic              en_a_q, en_a_d, en_b_q, en_b_d, conflict_q, conflict_d;
    logic [REG_AW-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [XLEN-1:0]   data_a_q, data_a_d, data_b_q, data_b_d;

    wb_fifo #(
        .DEPTH(NPU_DEPTH),
        .AW   (REG_AW),
        .DW   (XLEN)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (fifo_push),
        .push_rd_i  (npu_wb_rd),
        .push_data_i(npu_wb_data),
        .pop_i      (fifo_pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (npu_fifo_count),
        .head_rd_o  (head_rd),
        .head_data_o(head_data),
        .pending_o  (npu_pending)
    );

    assign npu_wb_ready = !fifo_full;

    // rd==0 transfers are handshaken but never stored, so x0 can never be pending.
    always_comb begin
        fifo_push  = npu_wb_valid && npu_wb_ready && (npu_wb_rd != '0);
        collide    = !fifo_empty && cpu_wb_valid && (cpu_wb_rd == head_rd) && (cpu_wb_rd != '0);
        fifo_pop   = !fifo_empty && !collide;

        en_a_d     = cpu_wb_valid && (cpu_wb_rd != '0);
        addr_a_d   = en_a_d ? cpu_wb_rd : addr_a_q;
        data_a_d   = en_a_d ? cpu_wb_data : data_a_q;

        en_b_d     = fifo_pop;
        addr_b_d   = fifo_pop ? head_rd : addr_b_q;
        data_b_d   = fifo_pop ? head_data : data_b_q;

        conflict_d = conflict_q || collide;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_a_q     <= 1'b0;
            addr_a_q   <= '0;
            data_a_q   <= '0;
            en_b_q     <= 1'b0;
            addr_b_q   <= '0;
            data_b_q   <= '0;
            conflict_q <= 1'b0;
        end else begin
            en_a_q     <= en_a_d;
            addr_a_q   <= addr_a_d;
            data_a_q   <= data_a_d;
            en_b_q     <= en_b_d;
            addr_b_q   <= addr_b_d;
            data_b_q   <= data_b_d;
            conflict_q <= conflict_d;
        end
    end

    assign write_enable_a = en_a_q;
    assign write_addr_a   = addr_a_q;
    assign write_data_a   = data_a_q;
    assign write_enable_b = en_b_q;
    assign write_addr_b   = addr_b_q;
    assign write_data_b   = data_b_q;
    assign wb_conflict    = conflict_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_wb_valid;
    logic [4:0]  cpu_wb_rd;
    logic [63:0] cpu_wb_data;
    logic        npu_wb_valid;
    logic        npu_wb_ready;
    logic [4:0]  npu_wb_rd;
    logic [63:0] npu_wb_data;
    logic        write_enable_a;
    logic [4:0]  write_addr_a;
    logic [63:0] write_data_a;
    logic        write_enable_b;
    logic [4:0]  write_addr_b;
    logic [63:0] write_data_b;
    logic [31:0] npu_pending;
    logic [2:0]  npu_fifo_count;
    logic        wb_conflict;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_wb_valid  (cpu_wb_valid),
        .cpu_wb_rd     (cpu_wb_rd),
        .cpu_wb_data   (cpu_wb_data),
        .npu_wb_valid  (npu_wb_valid),
        .npu_wb_ready  (npu_wb_ready),
        .npu_wb_rd     (npu_wb_rd),
        .npu_wb_data   (npu_wb_data),
        .write_enable_a(write_enable_a),
        .write_addr_a  (write_addr_a),
        .write_data_a  (write_data_a),
        .write_enable_b(write_enable_b),
        .write_addr_b  (write_addr_b),
        .write_data_b  (write_data_b),
        .npu_pending   (npu_pending),
        .npu_fifo_count(npu_fifo_count),
        .wb_conflict   (wb_conflict)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic npu(input logic v, input logic [4:0] rd, input logic [63:0] d);
        npu_wb_valid = v;
        npu_wb_rd    = rd;
        npu_wb_data  = d;
    endtask

    task automatic cpu(input logic v, input logic [4:0] rd, input logic [63:0] d);
        cpu_wb_valid = v;
        cpu_wb_rd    = rd;
        cpu_wb_data  = d;
    endtask

    initial begin
        rst_n = 1'b0;
        cpu(1'b0, 5'd0, 64'd0);
        npu(1'b0, 5'd0, 64'd0);
        tick();
        tick();
        chk("rst_en_a", 64'(write_enable_a), 64'd0);
        chk("rst_en_b", 64'(write_enable_b), 64'd0);
        chk("rst_count", 64'(npu_fifo_count), 64'd0);
        chk("rst_pending", 64'(npu_pending), 64'd0);
        chk("rst_conflict", 64'(wb_conflict), 64'd0);
        chk("rst_ready", 64'(npu_wb_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Port A latency and rd==0 drop
        cpu(1'b1, 5'd5, 64'hDEAD);
        tick();
        chk("a_en", 64'(write_enable_a), 64'd1);
        chk("a_addr", 64'(write_addr_a), 64'd5);
        chk("a_data", write_data_a, 64'hDEAD);
        cpu(1'b1, 5'd0, 64'h1234);
        tick();
        chk("a_rd0_en", 64'(write_enable_a), 64'd0);
        cpu(1'b0, 5'd0, 64'd0);

        // Back-to-back NPU stream drains concurrently
        npu(1'b1, 5'd7, 64'h700);
        tick();
        chk("s_count1", 64'(npu_fifo_count), 64'd1);
        chk("s_pend7", 64'(npu_pending), 64'h80);
        chk("s_enb0", 64'(write_enable_b), 64'd0);
        npu(1'b1, 5'd8, 64'h800);
        tick();
        chk("s_enb7", 64'(write_enable_b), 64'd1);
        chk("s_addr7", 64'(write_addr_b), 64'd7);
        chk("s_data7", write_data_b, 64'h700);
        chk("s_pend8", 64'(npu_pending), 64'h100);
        npu(1'b1, 5'd9, 64'h900);
        tick();
        chk("s_addr8", 64'(write_addr_b), 64'd8);
        chk("s_pend9", 64'(npu_pending), 64'h200);
        npu(1'b1, 5'd10, 64'hA00);
        tick();
        chk("s_addr9", 64'(write_addr_b), 64'd9);
        chk("s_pend10", 64'(npu_pending), 64'h400);
        npu(1'b0, 5'd0, 64'd0);
        tick();
        chk("s_en10", 64'(write_enable_b), 64'd1);
        chk("s_addr10", 64'(write_addr_b), 64'd10);
        chk("s_data10", write_data_b, 64'hA00);
        chk("s_count0", 64'(npu_fifo_count), 64'd0);
        chk("s_pend0", 64'(npu_pending), 64'd0);
        tick();
        chk("s_idle_enb", 64'(write_enable_b), 64'd0);

        // Same-rd collision: port A wins, sticky flag, retry next cycle
        npu(1'b1, 5'd12, 64'hC12);
        tick();
        chk("c_pend12", 64'(npu_pending), 64'h1000);
        npu(1'b0, 5'd0, 64'd0);
        cpu(1'b1, 5'd12, 64'hC0);
        tick();
        chk("c_en_a", 64'(write_enable_a), 64'd1);
        chk("c_addr_a", 64'(write_addr_a), 64'd12);
        chk("c_enb0", 64'(write_enable_b), 64'd0);
        chk("c_flag", 64'(wb_conflict), 64'd1);
        chk("c_count1", 64'(npu_fifo_count), 64'd1);
        cpu(1'b0, 5'd0, 64'd0);
        tick();
        chk("c_retry_en", 64'(write_enable_b), 64'd1);
        chk("c_retry_addr", 64'(write_addr_b), 64'd12);
        chk("c_retry_data", write_data_b, 64'hC12);
        chk("c_sticky", 64'(wb_conflict), 64'd1);
        chk("c_count0", 64'(npu_fifo_count), 64'd0);

        // Fill the FIFO while collisions hold the head
        cpu(1'b1, 5'd3, 64'hFF);
        for (int i = 0; i < 4; i++) begin
            npu(1'b1, 5'd3, 64'h30 + 64'(i));
            tick();
        end
        chk("f_count4", 64'(npu_fifo_count), 64'd4);
        chk("f_ready0", 64'(npu_wb_ready), 64'd0);
        chk("f_pend3", 64'(npu_pending), 64'h8);
        tick();
        chk("f_hold_count", 64'(npu_fifo_count), 64'd4);
        npu(1'b0, 5'd0, 64'd0);
        cpu(1'b0, 5'd0, 64'd0);
        tick();
        chk("f_count3", 64'(npu_fifo_count), 64'd3);
        chk("f_ready1", 64'(npu_wb_ready), 64'd1);
        chk("f_data0", write_data_b, 64'h30);
        tick();
        chk("f_data1", write_data_b, 64'h31);
        tick();
        chk("f_data2", write_data_b, 64'h32);
        tick();
        chk("f_data3", write_data_b, 64'h33);
        chk("f_empty", 64'(npu_fifo_count), 64'd0);
        tick();

        // rd==0 NPU transfer consumed, never queued
        npu(1'b1, 5'd0, 64'h1);
        tick();
        chk("z_count", 64'(npu_fifo_count), 64'd0);
        chk("z_pend", 64'(npu_pending), 64'd0);
        npu(1'b0, 5'd0, 64'd0);
        tick();
        chk("z_enb", 64'(write_enable_b), 64'd0);

        // Asynchronous reset with three entries queued
        npu(1'b1, 5'd20, 64'h20);
        tick();
        cpu(1'b1, 5'd20, 64'hAA);
        npu(1'b1, 5'd21, 64'h21);
        tick();
        npu(1'b1, 5'd22, 64'h22);
        tick();
        npu(1'b0, 5'd0, 64'd0);
        cpu(1'b0, 5'd0, 64'd0);
        chk("r_count3", 64'(npu_fifo_count), 64'd3);
        chk("r_pend", 64'(npu_pending), 64'h0070_0000);
        chk("r_en_a_pre", 64'(write_enable_a), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("r_async_en_a", 64'(write_enable_a), 64'd0);
        chk("r_async_addr_a", 64'(write_addr_a), 64'd0);
        chk("r_async_count", 64'(npu_fifo_count), 64'd0);
        chk("r_async_pend", 64'(npu_pending), 64'd0);
        chk("r_async_flag", 64'(wb_conflict), 64'd0);
        chk("r_async_data_b", write_data_b, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r_no_stale_enb", 64'(write_enable_b), 64'd0);
            chk("r_no_stale_cnt", 64'(npu_fifo_count), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
